// File: rtl/alu_issue_if.sv
// Bundle-in / result-out handshake plus the operand/result wires to the
// combinational ALU.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               Opcode;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic [DATA_WIDTH-1:0]    RdataA;
  logic [DATA_WIDTH-1:0]    RdataB;
  logic [DATA_WIDTH-1:0]    Imm;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] ALUCC;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    Result;
  logic                     IllegalOp;

  // The controller side.
  modport master (
    input  in_valid, Opcode, Funct3, Funct7, RdataA, RdataB, Imm,
           ALUResult, out_ready,
    output in_ready, SrcA, SrcB, ALUCC, out_valid, Result, IllegalOp
  );

  // Instruction source, ALU and result consumer.
  modport slave (
    output in_valid, Opcode, Funct3, Funct7, RdataA, RdataB, Imm,
           ALUResult, out_ready,
    input  in_ready, SrcA, SrcB, ALUCC, out_valid, Result, IllegalOp
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one RV instruction bundle per handshake,
// drives registered operands to the ALU and returns the captured result.
//
// state | meaning
// IDLE  | ready for a bundle; operands hold last legal values
// EXEC  | operands held on the ALU, down-counter running to capture
// HOLD  | Result/IllegalOp presented, waiting for out_ready
module alu_issue_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int OPCODE_LENGTH = 4,
  parameter int MUL_CYCLES    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [OPCODE_LENGTH-1:0] CC_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] CC_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] CC_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] CC_MUL = OPCODE_LENGTH'(4'b0000);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);

  logic [1:0]               state;
  logic [3:0]               count;
  logic                     dec_legal;
  logic                     dec_use_imm;
  logic                     dec_mul;
  logic [OPCODE_LENGTH-1:0] dec_cc;
  logic                     accept;

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_mul     = 1'b0;
    dec_cc      = CC_ADD;
    case (bus.Opcode)
      OP_R: begin
        if (bus.Funct3 == 3'b000 && bus.Funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_cc    = CC_ADD;
        end else if (bus.Funct3 == 3'b000 && bus.Funct7 == 7'b0100000) begin
          dec_legal = 1'b1;
          dec_cc    = CC_SUB;
        end else if (bus.Funct3 == 3'b110 && bus.Funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_cc    = CC_OR;
        end else if (bus.Funct3 == 3'b000 && bus.Funct7 == 7'b0000001) begin
          dec_legal = 1'b1;
          dec_mul   = 1'b1;
          dec_cc    = CC_MUL;
        end
      end
      OP_IMM: begin
        dec_use_imm = 1'b1;
        if (bus.Funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_cc    = CC_ADD;
        end else if (bus.Funct3 == 3'b110) begin
          dec_legal = 1'b1;
          dec_cc    = CC_OR;
        end
      end
      OP_LD, OP_ST: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
        dec_cc      = CC_ADD;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept        = (state == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      bus.SrcA      <= '0;
      bus.SrcB      <= '0;
      bus.ALUCC     <= CC_ADD;
      bus.Result    <= '0;
      bus.IllegalOp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              bus.SrcA  <= bus.RdataA;
              bus.SrcB  <= dec_use_imm ? bus.Imm : bus.RdataB;
              bus.ALUCC <= dec_cc;
              count     <= dec_mul ? MUL_LOAD : 4'd1;
              state     <= EXEC;
            end else begin
              // Illegal encodings never touch the ALU operands.
              bus.Result    <= '0;
              bus.IllegalOp <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        EXEC: begin
          if (count == 4'd1) begin
            bus.Result    <= bus.ALUResult;
            bus.IllegalOp <= 1'b0;
            count         <= '0;
            state         <= HOLD;
          end else begin
            count <= count - 4'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
